// File: rtl/dds_freq_meter.sv
// dds_freq_meter: recovers a DDS frequency control word from a sampled
// signed waveform. It counts clock cycles over 2^NP input periods, where
// a period runs between rising zero-crossings detected with hysteresis.
// It then divides 2^(PW+NP) by that count with a restoring divider.
//
// Ports:
//   clk      system clock
//   rst      synchronous, active-high reset
//   en       measurement enable; low forces IDLE and aborts any divide
//   in       signed input sample, one per clock
//   freq     measured frequency word (same scaling as the DDS word), held
//   valid    one-cycle pulse when freq is updated
//   timeout  high in a valid cycle whose result is a timeout (freq = 0)
//   busy     divider running
module dds_freq_meter #(
    parameter int PW   = 32,
    parameter int DW   = 10,
    parameter int NP   = 4,
    parameter int CW   = 24,
    parameter int HYST = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic signed [DW-1:0] in,
    output logic signed [PW-1:0] freq,
    output logic                 valid,
    output logic                 timeout,
    output logic                 busy
);

    localparam int QW  = PW + NP + 1;          // quotient bits = divide iterations
    localparam int ITW = $clog2(QW);
    localparam logic signed [DW-1:0] HP = DW'(HYST);
    localparam logic signed [DW-1:0] HN = -HP;
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};
    // Largest positive PW-bit signed word, widened to the quotient width.
    localparam logic [QW-1:0] FMAX = {{(NP + 2){1'b0}}, {(PW - 1){1'b1}}};

    typedef enum logic {IDLE, MEAS} state_t;

    state_t               state, state_n;
    logic signed [DW-1:0] s;
    logic                 arm;
    logic [CW-1:0]        cnt;      // cycles in the current window
    logic [CW-1:0]        icnt;     // cycles spent in IDLE without a crossing
    logic [NP-1:0]        ncross;
    logic [CW-1:0]        dvs;
    logic [CW-1:0]        rem;
    logic [CW-1:0]        rem_n;
    logic [QW-2:0]        quo;
    logic [QW-1:0]        q_next;
    logic [ITW-1:0]       it;
    logic [CW:0]          trial;
    logic                 qbit;
    logic                 x, close, tmo, start_div;

    // Crossing detection, window control and next state.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        x         = en && arm && (s >= HP);
        close     = (state == MEAS) && x && (ncross == {NP{1'b1}});
        // A closing crossing beats a timeout; an IDLE crossing also prevents one.
        tmo       = en && !close &&
                    (((state == MEAS) && (cnt == CMAX)) ||
                     ((state == IDLE) && !x && (icnt == CMAX)));
        start_div = close && !busy;
        state_n   = state;
        if (!en || tmo) begin
            state_n = IDLE;
        end else if ((state == IDLE) && x) begin
            state_n = MEAS;
        end
    end

    // One restoring-divide step. The dividend 2^(PW+NP) is a single one
    // followed by zeros, so only the first iteration shifts in a 1.
    always_comb begin
        trial = {rem, (it == '0)};
        qbit  = 1'b0;
        rem_n = trial[CW-1:0];
        if (trial >= {1'b0, dvs}) begin
            qbit  = 1'b1;
            rem_n = CW'(trial - {1'b0, dvs});
        end
        q_next = {quo, qbit};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s       <= '0;
            arm     <= 1'b0;
            cnt     <= '0;
            icnt    <= '0;
            ncross  <= '0;
            dvs     <= '0;
            rem     <= '0;
            quo     <= '0;
            it      <= '0;
            busy    <= 1'b0;
            freq    <= '0;
            valid   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            s       <= in;
            valid   <= 1'b0;
            timeout <= 1'b0;

            if (!en || tmo || x) begin
                arm <= 1'b0;
            end else if (s <= HN) begin
                arm <= 1'b1;
            end

            if (!en || tmo) begin
                cnt    <= '0;
                icnt   <= '0;
                ncross <= '0;
            end else if (state == IDLE) begin
                if (x) begin
                    cnt    <= CW'(1);
                    ncross <= '0;
                    icnt   <= '0;
                end else begin
                    icnt <= icnt + 1'b1;
                end
            end else if (close) begin
                // The closing crossing is also the first edge of the next window.
                cnt    <= CW'(1);
                ncross <= '0;
            end else begin
                cnt <= cnt + 1'b1;
                if (x) begin
                    ncross <= ncross + 1'b1;
                end
            end

            if (tmo) begin
                valid   <= 1'b1;
                timeout <= 1'b1;
                freq    <= '0;
            end

            if (!en || tmo) begin
                busy <= 1'b0;
            end else if (start_div) begin
                busy <= 1'b1;
                dvs  <= cnt;
                rem  <= '0;
                quo  <= '0;
                it   <= '0;
            end else if (busy) begin
                rem <= rem_n;
                quo <= q_next[QW-2:0];
                it  <= it + 1'b1;
                if (it == ITW'(QW - 1)) begin
                    busy  <= 1'b0;
                    valid <= 1'b1;
                    freq  <= (q_next > FMAX) ? FMAX[PW-1:0] : q_next[PW-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_dds_freq_meter.sv
// Self-checking bench for dds_freq_meter. A square-wave "DDS" (phase
// accumulator plus optional noise) drives the input. A timestamp-level
// reference model turns the crossing times into expected results, each
// tagged with the cycle in which valid must appear. A monitor pops and
// compares those results whenever the DUT raises valid.
module tb_dds_freq_meter;

    localparam int PW   = 16;
    localparam int DW   = 10;
    localparam int NP   = 2;
    localparam int CW   = 10;
    localparam int HYST = 8;
    localparam int QW   = PW + NP + 1;
    localparam int CMAX = (1 << CW) - 1;
    localparam longint FMAXV = (64'sd1 <<< (PW - 1)) - 1;
    localparam int NEVER = -1000000;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 en  = 1'b0;
    logic signed [DW-1:0] in_s = '0;
    logic signed [PW-1:0] freq;
    logic                 valid, timeout, busy;

    dds_freq_meter #(.PW(PW), .DW(DW), .NP(NP), .CW(CW), .HYST(HYST)) dut (
        .clk(clk), .rst(rst), .en(en), .in(in_s),
        .freq(freq), .valid(valid), .timeout(timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int     due;
        bit     tmo;
        longint f;
    } exp_t;

    exp_t   sbq[$];
    int     n_pass = 0;
    int     n_total = 0;
    int     n_results = 0;
    longint hold = 0;

    task automatic check(input string name, input longint got, input longint want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, got, want, cyc);
    endtask

    // Reference model: timestamps of window start, idle start and divide start.
    bit m_meas, m_arm;
    int m_start, m_i0, m_ncross, m_last, m_prev;

    function automatic void flush(input int u);
        while (sbq.size() > 0 && sbq[$].due > u) void'(sbq.pop_back());
    endfunction

    function automatic void push(input int due, input bit tmo, input longint f);
        exp_t e;
        e.due = due; e.tmo = tmo; e.f = f;
        sbq.push_back(e);
    endfunction

    function automatic void m_reset(input int t);
        m_meas = 0; m_arm = 0; m_ncross = 0;
        m_i0 = t + 1; m_start = 0; m_last = NEVER; m_prev = 0;
    endfunction

    function automatic void m_timeout(input int u);
        flush(u);
        push(u + 1, 1'b1, 0);
        m_meas = 0; m_arm = 0; m_i0 = u + 1; m_last = NEVER;
    endfunction

    // Evaluate cycle u, where s is the registered sample seen in that cycle.
    function automatic void m_step(input int u, input bit en_v, input int s);
        bit     x;
        longint q;
        int     d;
        if (!en_v) begin
            flush(u);
            m_meas = 0; m_arm = 0; m_ncross = 0; m_i0 = u + 1; m_last = NEVER;
            return;
        end
        x = m_arm && (s >= HYST);
        if (x) m_arm = 0;
        else if (s <= -HYST) m_arm = 1;
        if (m_meas) begin
            if (x && (m_ncross + 1 == (1 << NP))) begin
                d = u - m_start;
                if (u > m_last + QW) begin
                    q = (64'sd1 <<< (PW + NP)) / d;
                    if (q > FMAXV) q = FMAXV;
                    push(u + QW + 1, 1'b0, q);
                    m_last = u;
                end
                m_start = u; m_ncross = 0;
            end else begin
                if (x) m_ncross++;
                if (u - m_start == CMAX) m_timeout(u);
            end
        end else if (x) begin
            m_meas = 1; m_start = u; m_ncross = 0;
        end else if (u - m_i0 == CMAX) begin
            m_timeout(u);
        end
    endfunction

    // Square-wave DDS source.
    logic [PW-1:0] g_phase = '0;
    logic [PW-1:0] g_word = '0;
    int            g_amp = 300;
    int            g_noise = 0;

    function automatic int gen_next();
        int v;
        v = g_phase[PW-1] ? -g_amp : g_amp;
        if (g_noise > 0) v = v + int'($urandom_range(0, 2 * g_noise)) - g_noise;
        g_phase = g_phase + g_word;
        return v;
    endfunction

    task automatic tick(input bit r, input bit e, input int v);
        @(posedge clk);
        #1;
        rst = r; en = e; in_s = DW'(v);
        if (r) begin
            flush(cyc);
            m_reset(cyc);
        end else begin
            m_step(cyc, e, m_prev);
            m_prev = v;
        end
    endtask

    task automatic run(input int n, input bit e);
        repeat (n) tick(1'b0, e, gen_next());
    endtask

    // Monitor: every valid must match the head of the scoreboard, on time.
    always @(negedge clk) begin
        exp_t e;
        if (rst) hold = 0;
        while (sbq.size() > 0 && sbq[0].due < cyc) begin
            e = sbq.pop_front();
            check("missed_valid", cyc, e.due);
        end
        if (valid) begin
            if (sbq.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = sbq.pop_front();
                check("valid_cycle", cyc, e.due);
                check("timeout_flag", timeout, e.tmo);
                check("freq", freq, e.f);
                hold = e.f;
                n_results++;
            end
        end
    end

    task automatic wait_busy(output bit seen);
        seen = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            tick(1'b0, 1'b1, gen_next());
            seen = busy;
        end
        check("busy_seen", seen, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end expected finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        m_reset(0);
        repeat (3) tick(1'b1, 1'b0, 0);
        @(negedge clk);
        check("reset_freq", freq, 0);
        check("reset_valid", valid, 0);
        check("reset_timeout", timeout, 0);
        check("reset_busy", busy, 0);

        // Period 16: exact word 2^(PW-4).
        g_word = PW'(1 << (PW - 4)); g_amp = 300; g_noise = 0;
        run(700, 1'b1);
        // Period 4: D = 16.
        g_word = PW'(1 << (PW - 2));
        run(400, 1'b1);
        // Period 2: fclk/2, saturates; windows overrun the divider.
        g_word = PW'(1 << (PW - 1));
        run(300, 1'b1);
        @(negedge clk);
        check("hold_sat", freq, hold);

        // Random tuning words with noise around the hysteresis band.
        for (int k = 0; k < 4; k++) begin
            g_word = PW'($urandom_range(300, 16000));
            g_noise = int'($urandom_range(0, 40));
            run(1500, 1'b1);
        end
        g_noise = 0;

        // Flat input: IDLE timeouts.
        g_amp = 0;
        run(2200, 1'b1);
        @(negedge clk);
        check("hold_timeout", freq, hold);

        // Window longer than the counter range: MEAS timeouts.
        g_amp = 300; g_word = PW'(218);
        run(3000, 1'b1);

        // en dropped mid-divide.
        g_word = PW'(1 << (PW - 4));
        wait_busy(seen);
        tick(1'b0, 1'b0, gen_next());
        tick(1'b0, 1'b0, gen_next());
        check("en_abort_busy", busy, 0);
        check("en_abort_valid", valid, 0);
        check("en_abort_freq", freq, hold);
        run(20, 1'b0);
        run(700, 1'b1);

        // rst pulse mid-divide.
        wait_busy(seen);
        tick(1'b1, 1'b0, 0);
        tick(1'b0, 1'b1, gen_next());
        check("rst_abort_busy", busy, 0);
        check("rst_abort_valid", valid, 0);
        check("rst_abort_freq", freq, 0);
        g_word = PW'(1 << (PW - 2));
        run(700, 1'b1);

        run(5, 1'b0);
        @(negedge clk);
        check("results_seen", (n_results >= 30) ? 1 : 0, 1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
